csi_sequence_parser: RTL

- Byte-level front end of the parser: consumes the received character stream and emits one-cycle command strobes for the mode-control, cursor and text stages.
- Recognises ESC [ (CSI) sequences with an optional '?' private marker.
- Accumulates decimal parameters and emits INIT_PN, EMIT_PN and final commands; the final command carries the last parameter.
- Non-sequence bytes pass through as PRINT or CONTROL commands.

---
 rtl/csi_sequence_parser.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/csi_sequence_parser.sv
// csi_sequence_parser: byte-stream front end that turns ESC [ ... sequences,
// printable bytes and control bytes into one-cycle command strobes.
// Ports:
//   clk, rst (async, active-low)
//   data_valid, data[7:0]          : rx byte stream (data_ready is always 1)
//   command_ready                  : one-cycle strobe, registered
//   command_type[3:0]              : 0 NONE .. 9 CONTROL
//   param_pns[7:0], char_out[7:0]  : parameter / byte carried with the strobe
// Optional build macro: CSI_CAN_ABORT_EN (CAN/SUB abort an open sequence).
module csi_sequence_parser #(
    parameter int MAX_PARAMS = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       data_valid,
    input  logic [7:0] data,
    output logic       data_ready,
    output logic       command_ready,
    output logic [3:0] command_type,
    output logic [7:0] param_pns,
    output logic [7:0] char_out
);

    localparam int CW = $clog2(MAX_PARAMS + 1);

    localparam logic [3:0] CMD_NONE      = 4'd0;
    localparam logic [3:0] CMD_INIT_PN   = 4'd1;
    localparam logic [3:0] CMD_EMIT_PN   = 4'd2;
    localparam logic [3:0] CMD_SETMODE   = 4'd3;
    localparam logic [3:0] CMD_RESETMODE = 4'd4;
    localparam logic [3:0] CMD_SETDEC    = 4'd5;
    localparam logic [3:0] CMD_RESETDEC  = 4'd6;
    localparam logic [3:0] CMD_CSI_OTHER = 4'd7;
    localparam logic [3:0] CMD_PRINT     = 4'd8;
    localparam logic [3:0] CMD_CONTROL   = 4'd9;

    localparam logic [7:0] ESC = 8'h1B;

    typedef enum logic [2:0] {
        GROUND,
        ESCAPE,
        CSI_ENTRY,
        CSI_PARAM,
        CSI_IGNORE
    } state_t;

    state_t          state_q, state_d;
    logic            rdy_q, rdy_d;
    logic [3:0]      type_q, type_d;
    logic [7:0]      pns_q, pns_d;
    logic [7:0]      chr_q, chr_d;
    logic [7:0]      acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            dec_q, dec_d;

    logic [11:0]     acc_ext;
    logic [7:0]      acc_sat;
    logic            is_digit;
    logic            is_final;

    assign data_ready    = 1'b1;
    assign command_ready = rdy_q;
    assign command_type  = type_q;
    assign param_pns     = pns_q;
    assign char_out      = chr_q;

    // Digit value is the low nibble of '0'..'9'; the wide sum cannot
    // overflow 12 bits (255*10+9), so clamp afterwards.
    assign acc_ext  = 12'(acc_q) * 12'd10 + 12'(data[3:0]);
    assign acc_sat  = (acc_ext > 12'd255) ? 8'hFF : acc_ext[7:0];
    assign is_digit = (data >= 8'h30) && (data <= 8'h39);
    assign is_final = (data >= 8'h40) && (data <= 8'h7E);

    always_comb begin
        state_d = state_q;
        rdy_d   = 1'b0;
        type_d  = CMD_NONE;
        pns_d   = pns_q;
        chr_d   = chr_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        dec_d   = dec_q;

        if (data_valid) begin
`ifdef CSI_CAN_ABORT_EN
            if ((state_q != GROUND) &&
                ((data == 8'h18) || (data == 8'h1A))) begin
                state_d = GROUND;
                rdy_d   = 1'b1;
                type_d  = CMD_CONTROL;
                chr_d   = data;
                acc_d   = 8'd0;
                cnt_d   = '0;
            end else
`endif
            case (state_q)
                GROUND: begin
                    if (data == ESC) begin
                        state_d = ESCAPE;
                    end else if ((data >= 8'h20) && (data <= 8'h7E)) begin
                        rdy_d  = 1'b1;
                        type_d = CMD_PRINT;
                        chr_d  = data;
                    end else begin
                        rdy_d  = 1'b1;
                        type_d = CMD_CONTROL;
                        chr_d  = data;
                    end
                end
                ESCAPE: begin
                    if (data == 8'h5B) begin
                        state_d = CSI_ENTRY;
                        rdy_d   = 1'b1;
                        type_d  = CMD_INIT_PN;
                        acc_d   = 8'd0;
                        cnt_d   = '0;
                        dec_d   = 1'b0;
                    end else if (data != ESC) begin
                        state_d = GROUND;
                    end
                end
                CSI_ENTRY, CSI_PARAM: begin
                    if ((state_q == CSI_ENTRY) && (data == 8'h3F)) begin
                        dec_d   = 1'b1;
                        state_d = CSI_PARAM;
                    end else if (is_digit) begin
                        acc_d   = acc_sat;
                        state_d = CSI_PARAM;
                    end else if (data == 8'h3B) begin
                        if (cnt_q < CW'(MAX_PARAMS)) begin
                            rdy_d  = 1'b1;
                            type_d = CMD_EMIT_PN;
                            pns_d  = acc_q;
                            cnt_d  = cnt_q + CW'(1);
                        end
                        acc_d   = 8'd0;
                        state_d = CSI_PARAM;
                    end else if (data == 8'h68) begin
                        rdy_d   = 1'b1;
                        type_d  = dec_q ? CMD_SETDEC : CMD_SETMODE;
                        pns_d   = acc_q;
                        state_d = GROUND;
                    end else if (data == 8'h6C) begin
                        rdy_d   = 1'b1;
                        type_d  = dec_q ? CMD_RESETDEC : CMD_RESETMODE;
                        pns_d   = acc_q;
                        state_d = GROUND;
                    end else if (is_final) begin
                        rdy_d   = 1'b1;
                        type_d  = CMD_CSI_OTHER;
                        pns_d   = acc_q;
                        chr_d   = data;
                        state_d = GROUND;
                    end else if (data == ESC) begin
                        state_d = ESCAPE;
                    end else if (data < 8'h20) begin
                        // Embedded controls execute without disturbing
                        // the sequence being collected.
                        rdy_d  = 1'b1;
                        type_d = CMD_CONTROL;
                        chr_d  = data;
                    end else if (data <= 8'h3F) begin
                        // Intermediates, late '?', and unsupported
                        // parameter characters spoil the sequence.
                        state_d = CSI_IGNORE;
                    end
                end
                CSI_IGNORE: begin
                    if (is_final) begin
                        state_d = GROUND;
                    end else if (data == ESC) begin
                        state_d = ESCAPE;
                    end
                end
                default: state_d = GROUND;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= GROUND;
            rdy_q   <= 1'b0;
            type_q  <= CMD_NONE;
            pns_q   <= 8'd0;
            chr_q   <= 8'd0;
            acc_q   <= 8'd0;
            cnt_q   <= '0;
            dec_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rdy_q   <= rdy_d;
            type_q  <= type_d;
            pns_q   <= pns_d;
            chr_q   <= chr_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            dec_q   <= dec_d;
        end
    end

endmodule
